// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master read arbiter: FSM state, one-hot owner codes, AXI read responses.
// Pure definitions, no logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle; master modport drives address and rready.
// No logic; the modport direction decides who is master and who is slave.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational one-hot pick between two requesters; zero latency, no backpressure of its own.
// MEM_READ_ARBITER_RR_EN: ties go to the master that did not own last; otherwise M1 wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
`ifdef MEM_READ_ARBITER_RR_EN
    input  logic       last_owner,
`endif
    output logic [1:0] pick
);

    always_comb begin
        pick = OWN_NONE;
        if (req0 && req1) begin
`ifdef MEM_READ_ARBITER_RR_EN
            // last_owner is 1 when M1 held the previous grant
            pick = last_owner ? OWN_M0 : OWN_M1;
`else
            pick = OWN_M1;
`endif
        end else if (req1) begin
            pick = OWN_M1;
        end else if (req0) begin
            pick = OWN_M0;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Two-master AXI4-Lite read arbiter (M0 IFU, M1 LSU) onto one slave, one read in flight.
// Latency: one IDLE arbitration cycle per transaction, routing itself adds none; rready passes straight through.
// MEM_READ_ARBITER_RR_EN: ties alternate via last_owner; otherwise M1 wins ties.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_read_arbiter_if.slave  m0,
    mem_read_arbiter_if.slave  m1,
    mem_read_arbiter_if.master s,
    output logic [1:0]         grant,
    output logic               busy
);

    state_t            state, state_nxt;
    logic [1:0]        owner, owner_nxt, pick;
    logic              own0, own1, in_addr, in_data;
    logic [ADDR_W-1:0] araddr_sel;
    logic [DATA_W-1:0] rdata_fwd;

`ifdef MEM_READ_ARBITER_RR_EN
    logic last_owner;
`endif

    mem_arb_pick u_pick (
        .req0       (m0.arvalid),
        .req1       (m1.arvalid),
`ifdef MEM_READ_ARBITER_RR_EN
        .last_owner (last_owner),
`endif
        .pick       (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef MEM_READ_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && pick != OWN_NONE) begin
            last_owner <= pick[1];
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                if (pick != OWN_NONE) begin
                    owner_nxt = pick;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                // owner dropping arvalid here is illegal; we simply keep waiting
                if (s.arvalid && s.arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (s.rvalid && s.rready) begin
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
        endcase
    end

    // Gating with rst keeps every handshake output quiet while reset is held.
    assign own0       = rst && (owner == OWN_M0);
    assign own1       = rst && (owner == OWN_M1);
    assign in_addr    = (state == ADDR);
    assign in_data    = (state == DATA);
    assign araddr_sel = own1 ? m1.araddr : (own0 ? m0.araddr : '0);
    assign rdata_fwd  = in_data ? s.rdata : '0;

    always_comb begin
        s.araddr   = '0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        m0.rdata   = '0;
        m1.rdata   = '0;
        m0.rresp   = 2'b00;
        m1.rresp   = 2'b00;
        if (in_addr) begin
            s.araddr   = araddr_sel;
            s.arvalid  = (own0 && m0.arvalid) || (own1 && m1.arvalid);
            m0.arready = own0 && s.arready;
            m1.arready = own1 && s.arready;
        end
        if (in_data) begin
            s.rready  = (own0 && m0.rready) || (own1 && m1.rready);
            m0.rvalid = own0 && s.rvalid;
            m1.rvalid = own1 && s.rvalid;
            m0.rdata  = own0 ? rdata_fwd : '0;
            m1.rdata  = own1 ? rdata_fwd : '0;
            m0.rresp  = own0 ? s.rresp : 2'b00;
            m1.rresp  = own1 ? s.rresp : 2'b00;
        end
    end

    assign grant = owner;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter against a transaction-order model.
// Follows MEM_READ_ARBITER_RR_EN for the expected tie winner.
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;
    logic       busy;
    int         total = 0;
    int         bad = 0;
    int         rr_last = 1;

    mem_read_arbiter_if m0 ();
    mem_read_arbiter_if m1 ();
    mem_read_arbiter_if s ();

    mem_read_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0),
        .m1    (m1),
        .s     (s),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0.araddr  = '0;
        m0.arvalid = 1'b0;
        m0.rready  = 1'b0;
        m1.araddr  = '0;
        m1.arvalid = 1'b0;
        m1.rready  = 1'b0;
        s.arready  = 1'b0;
        s.rdata    = '0;
        s.rresp    = 2'b00;
        s.rvalid   = 1'b0;
    endtask

    // One arbitration round from IDLE: r0/r1 say who requests; every request is served to completion.
    task automatic run_trial(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                             input bit fixed, input logic [31:0] fdata, input int fdly,
                             input logic [1:0] frsp);
        int          order[$];
        int          cur = 0;
        int          dly = 0;
        bit          ar_done = 1'b0;
        bit          gap = 1'b0;
        bit          first = 1'b1;
        bit          drop = 1'b0;
        logic [31:0] rd = '0;
        logic [1:0]  rsp = 2'b00;
        logic [31:0] exp_addr;
        logic [1:0]  exp_grant;
        logic        own_arr, own_rv, own_rr, oth_arr, oth_rv;
        logic [31:0] own_rd;
        logic [1:0]  own_rsp;

        if (r0 && r1) begin
`ifdef MEM_READ_ARBITER_RR_EN
            if (rr_last == 1) order = '{0, 1};
            else              order = '{1, 0};
`else
            order = '{1, 0};
`endif
        end else if (r1) begin
            order = '{1};
        end else begin
            order = '{0};
        end
        rr_last = order[order.size()-1];

        m0.araddr  = a0;
        m0.arvalid = r0;
        m1.araddr  = a1;
        m1.arvalid = r1;
        for (int cyc = 0; cyc < 300 && cur < order.size(); cyc++) begin
            if (drop) begin
                if (order[cur] == 0) m0.arvalid = 1'b0;
                else                 m1.arvalid = 1'b0;
                drop = 1'b0;
            end
            m0.rready = ($urandom_range(0, 1) == 1);
            m1.rready = ($urandom_range(0, 1) == 1);
            s.arready = ($urandom_range(0, 3) != 0);
            if (ar_done) begin
                if (dly > 0) begin
                    dly--;
                    s.rvalid = 1'b0;
                end else begin
                    s.rvalid = 1'b1;
                end
                s.rdata = rd;
                s.rresp = rsp;
            end else begin
                s.rvalid = 1'b0;
                s.rdata  = $urandom;
                s.rresp  = 2'b00;
            end

            @(negedge clk);
            exp_grant = (order[cur] == 0) ? OWN_M0 : OWN_M1;
            exp_addr  = (order[cur] == 0) ? a0 : a1;
            own_arr   = (order[cur] == 0) ? m0.arready : m1.arready;
            own_rv    = (order[cur] == 0) ? m0.rvalid  : m1.rvalid;
            own_rr    = (order[cur] == 0) ? m0.rready  : m1.rready;
            own_rd    = (order[cur] == 0) ? m0.rdata   : m1.rdata;
            own_rsp   = (order[cur] == 0) ? m0.rresp   : m1.rresp;
            oth_arr   = (order[cur] == 0) ? m1.arready : m0.arready;
            oth_rv    = (order[cur] == 0) ? m1.rvalid  : m0.rvalid;

            if (first) begin
                chk("arb_cycle_busy", busy, 0);
                chk("arb_cycle_grant", grant, OWN_NONE);
                first = 1'b0;
            end
            if (gap) begin
                chk("idle_gap_busy", busy, 0);
                gap = 1'b0;
            end
            if (!busy) begin
                chk("idle_s_arvalid", s.arvalid, 0);
                chk("idle_arready", {m0.arready, m1.arready}, 0);
                chk("idle_rvalid", {m0.rvalid, m1.rvalid}, 0);
                chk("idle_grant", grant, OWN_NONE);
            end else begin
                chk("grant", grant, exp_grant);
                chk("other_arready", oth_arr, 0);
                chk("other_rvalid", oth_rv, 0);
                if (!ar_done)      chk("s_arvalid", s.arvalid, 1);
                else if (s.rvalid) chk("s_rready", s.rready, own_rr);
            end

            if (busy && !ar_done && s.arvalid && s.arready) begin
                chk("s_araddr", s.araddr, exp_addr);
                chk("own_arready", own_arr, 1);
                ar_done = 1'b1;
                drop    = 1'b1;
                dly     = fixed ? fdly  : $urandom_range(0, 3);
                rd      = fixed ? fdata : $urandom;
                rsp     = fixed ? frsp  : 2'($urandom_range(0, 3));
            end else if (busy && ar_done && s.rvalid && s.rready) begin
                chk("own_rvalid", own_rv, 1);
                chk("own_rdata", own_rd, rd);
                chk("own_rresp", own_rsp, rsp);
                ar_done = 1'b0;
                gap     = 1'b1;
                cur++;
            end
            @(posedge clk);
            #1;
        end
        if (cur < order.size()) begin
            chk("trial_timeout", cur, order.size());
            idle_inputs();
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            rr_last = 1;
        end
        idle_inputs();
    endtask

    task automatic reset_mid();
        m0.araddr  = 32'h8000_0010;
        m0.arvalid = 1'b1;
        s.arready  = 1'b1;
        m0.rready  = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m0.arvalid = 1'b0;
        s.rvalid   = 1'b1;
        s.rdata    = 32'hdead_beef;
        s.rresp    = OKAY;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_m0_rvalid", m0.rvalid, 1);
        chk("mid_backpressure", s.rready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_grant", grant, OWN_NONE);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_s_rready", s.rready, 0);
        chk("rst_mid_m0_rvalid", m0.rvalid, 0);
        chk("rst_mid_m1_rvalid", m1.rvalid, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        rr_last = 1;
    endtask

    initial begin
        int r;
        idle_inputs();
        rst = 1'b0;
        m0.arvalid = 1'b1;
        m1.arvalid = 1'b1;
        s.arready  = 1'b1;
        s.rvalid   = 1'b1;
        s.rdata    = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, OWN_NONE);
        chk("rst_busy", busy, 0);
        chk("rst_s_arvalid", s.arvalid, 0);
        chk("rst_s_rready", s.rready, 0);
        chk("rst_s_araddr", s.araddr, 0);
        chk("rst_arready", {m0.arready, m1.arready}, 0);
        chk("rst_rvalid", {m0.rvalid, m1.rvalid}, 0);
        chk("rst_rdata", {m0.rdata, m1.rdata}, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_trial(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0413, 2, OKAY);
        run_trial(1'b1, 1'b1, 32'h8000_0004, 32'h8000_1000, 1'b0, 32'h0, 0, OKAY);
        run_trial(1'b0, 1'b1, 32'h0, 32'h8000_2000, 1'b1, 32'hcafe_0001, 1, SLVERR);
        run_trial(1'b1, 1'b0, 32'h8000_3000, 32'h0, 1'b1, 32'hcafe_0002, 0, DECERR);
        for (int i = 0; i < 3; i++) begin
            run_trial(1'b1, 1'b1, 32'h8000_0100 + 32'(i), 32'h8000_0200 + 32'(i), 1'b0, 32'h0, 0, OKAY);
        end
        reset_mid();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            run_trial(r[0], r[1], $urandom, $urandom, 1'b0, 32'h0, 0, OKAY);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
